mem_dma: RTL

- Parametrised block-transfer engine on the shared single-port memory bus (read/ack, write-strobe protocol).
- Moves CLS, LD [I],Vx / LD Vx,[I] and screen fills out of the cpu sequencer into one reusable unit.
- Generalised in address/count width, with ascending/descending copy and fill modes.
- Sits between the cpu and the mem arbiter; the cpu issues `start` and waits on `done`.

---
 rtl/mem_dma.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_dma.sv
// Block-transfer engine on the shared memory bus: ascending/descending copy and fill.
// Define MEM_DMA_XOR_EN to build the XOR blit (mode 11) and the collision flag.
module mem_dma #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [7:0]        fill_byte,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_read_idx,
  input  logic [7:0]        mem_read_byte,
  input  logic              mem_read_ack,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_write_idx,
  output logic [7:0]        mem_write_byte
);

  typedef enum logic [2:0] {StIdle, StRdSrc, StRdDst, StWr, StDrain} state_e;

  localparam logic [1:0] ModeFill = 2'b01;
  localparam logic [1:0] ModeDesc = 2'b10;
  localparam logic [1:0] ModeXor  = 2'b11;

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [CNT_W-1:0]   off_q, rem_q;
  logic [7:0]         fill_q, sbyte_q;
  logic               done_q;
`ifdef MEM_DMA_XOR_EN
  logic [7:0]         dbyte_q;
  logic               coll_q;
  logic               drain_dst_q;
`endif

  logic [ADDR_W-1:0]  off_a, rd_addr, wr_addr;
  logic               rd_state, rd_dst;
  logic [7:0]         wr_data;

  assign off_a   = ADDR_W'(off_q);
  assign wr_addr = dst_q + off_a;

`ifdef MEM_DMA_XOR_EN
  assign rd_dst = (state_q == StRdDst) || ((state_q == StDrain) && drain_dst_q);
`else
  assign rd_dst = 1'b0;
`endif
  assign rd_addr  = rd_dst ? wr_addr : (src_q + off_a);
  assign rd_state = (state_q == StRdSrc) || (state_q == StRdDst) || (state_q == StDrain);

  always_comb begin
    wr_data = sbyte_q;
    if (mode_q == ModeFill) wr_data = fill_q;
`ifdef MEM_DMA_XOR_EN
    else if (mode_q == ModeXor) wr_data = sbyte_q ^ dbyte_q;
`endif
  end

  // Read request drops combinationally with ack; abort kills the write in the same cycle.
  assign mem_read       = rd_state && !mem_read_ack;
  assign mem_read_idx   = mem_read ? rd_addr : '0;
  assign mem_write      = (state_q == StWr) && !abort;
  assign mem_write_idx  = mem_write ? wr_addr : '0;
  assign mem_write_byte = mem_write ? wr_data : '0;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
`ifdef MEM_DMA_XOR_EN
  assign collision      = coll_q;
`else
  assign collision      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mode_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
      fill_q  <= '0;
      sbyte_q <= '0;
      done_q  <= 1'b0;
`ifdef MEM_DMA_XOR_EN
      dbyte_q     <= '0;
      coll_q      <= 1'b0;
      drain_dst_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            mode_q <= mode;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            fill_q <= fill_byte;
            rem_q  <= count;
            off_q  <= (mode == ModeDesc) ? count : '0;
            if (mode == ModeFill) begin
              state_q <= StWr;
            end else if (mode == ModeXor) begin
`ifdef MEM_DMA_XOR_EN
              coll_q  <= 1'b0;
              state_q <= StRdSrc;
`else
              done_q  <= 1'b1;
`endif
            end else begin
              state_q <= StRdSrc;
            end
          end
        end
        StRdSrc: begin
          if (mem_read_ack) begin
            sbyte_q <= mem_read_byte;
            if (abort) state_q <= StIdle;
`ifdef MEM_DMA_XOR_EN
            else if (mode_q == ModeXor) state_q <= StRdDst;
`endif
            else state_q <= StWr;
          end else if (abort) begin
            state_q <= StDrain;
`ifdef MEM_DMA_XOR_EN
            drain_dst_q <= 1'b0;
`endif
          end
        end
`ifdef MEM_DMA_XOR_EN
        StRdDst: begin
          if (mem_read_ack) begin
            if (abort) begin
              state_q <= StIdle;
            end else begin
              dbyte_q <= mem_read_byte;
              if ((sbyte_q & mem_read_byte) != 8'h00) coll_q <= 1'b1;
              state_q <= StWr;
            end
          end else if (abort) begin
            state_q     <= StDrain;
            drain_dst_q <= 1'b1;
          end
        end
`endif
        StWr: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (rem_q == '0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            rem_q   <= rem_q - CNT_W'(1);
            off_q   <= (mode_q == ModeDesc) ? off_q - CNT_W'(1) : off_q + CNT_W'(1);
            state_q <= (mode_q == ModeFill) ? StWr : StRdSrc;
          end
        end
        StDrain: begin
          if (mem_read_ack) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
